// File: rtl/assoc_lookup_unit.sv
// ---------------------------------------------------------------------------
// assoc_lookup_unit
//   Small associative (key -> data) table with N = 2**NUM_DATA_LOG2 entries.
//   Commands arrive as raw level lines and are edge-detected; write, delete
//   and lookup are executed by a sequential scan (one entry per cycle)
//   followed by a single commit cycle. Clear is immediate from any state.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   sync_reset   in   synchronous active-high reset
//   cmd_input    in   [0]=write [1]=lookup [2]=delete [3]=clear (levels)
//   key_input    in   command key
//   data_input   in   write data
//   data_output  out  data of the last successful lookup
//   data_valid   out  data_output holds a valid lookup result
//   hit          out  last committed command found its key
//   error        out  one-cycle pulse on a failed command
//   busy         out  FSM not idle
//   count        out  number of valid entries (0..N)
//   full         out  count == N
// ---------------------------------------------------------------------------
module assoc_lookup_unit #(
   parameter int unsigned KEY_WIDTH     = 4,
   parameter int unsigned DATA_WIDTH    = 2,
   parameter int unsigned NUM_DATA_LOG2 = 3,
   parameter bit          REPLACE_EN    = 1'b1
) (
   input  logic                     clk,
   input  logic                     sync_reset,
   input  logic [3:0]               cmd_input,
   input  logic [KEY_WIDTH-1:0]     key_input,
   input  logic [DATA_WIDTH-1:0]    data_input,
   output logic [DATA_WIDTH-1:0]    data_output,
   output logic                     data_valid,
   output logic                     hit,
   output logic                     error,
   output logic                     busy,
   output logic [NUM_DATA_LOG2:0]   count,
   output logic                     full
);

   localparam int unsigned N = 1 << NUM_DATA_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_e;
   typedef enum logic [1:0] {OP_WRITE, OP_DELETE, OP_LOOKUP} op_e;

   // Table storage; keys/data are qualified by valid_q so they need no reset.
   logic [N-1:0]            valid_q;
   logic [KEY_WIDTH-1:0]    key_q  [N];
   logic [DATA_WIDTH-1:0]   data_q [N];

   state_e                  state_q;
   op_e                     op_q;
   logic [KEY_WIDTH-1:0]    key_l_q;
   logic [DATA_WIDTH-1:0]   data_l_q;
   logic [NUM_DATA_LOG2-1:0] idx_q;
   logic                    match_q;
   logic [NUM_DATA_LOG2-1:0] match_idx_q;
   logic                    free_q;
   logic [NUM_DATA_LOG2-1:0] free_idx_q;
   logic [NUM_DATA_LOG2-1:0] rr_q;
   logic [NUM_DATA_LOG2:0]  count_q;

   logic [DATA_WIDTH-1:0]   data_out_q;
   logic                    data_valid_q;
   logic                    hit_q;
   logic                    error_q;

   logic [3:0]              cmd_prev_q;
   logic [3:0]              cmd_pulse;

   assign cmd_pulse = cmd_input & ~cmd_prev_q;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         valid_q      <= '0;
         state_q      <= S_IDLE;
         op_q         <= OP_LOOKUP;
         key_l_q      <= '0;
         data_l_q     <= '0;
         idx_q        <= '0;
         match_q      <= 1'b0;
         match_idx_q  <= '0;
         free_q       <= 1'b0;
         free_idx_q   <= '0;
         rr_q         <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         error_q      <= 1'b0;
         cmd_prev_q   <= '0;
      end else begin
         cmd_prev_q <= cmd_input;
         error_q    <= 1'b0;
         if (cmd_pulse[3]) begin
            // Clear overrides everything, including a scan in flight.
            valid_q      <= '0;
            count_q      <= '0;
            rr_q         <= '0;
            data_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            state_q      <= S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (|cmd_pulse[2:0]) begin
                     op_q     <= cmd_pulse[0] ? OP_WRITE :
                                 (cmd_pulse[2] ? OP_DELETE : OP_LOOKUP);
                     key_l_q  <= key_input;
                     data_l_q <= data_input;
                     idx_q    <= '0;
                     match_q  <= 1'b0;
                     free_q   <= 1'b0;
                     state_q  <= S_SCAN;
                  end
               end
               S_SCAN: begin
                  if (valid_q[idx_q] && (key_q[idx_q] == key_l_q)) begin
                     match_q     <= 1'b1;
                     match_idx_q <= idx_q;
                     state_q     <= S_COMMIT;
                  end else begin
                     // First invalid slot seen is the lowest free index.
                     if (!valid_q[idx_q] && !free_q) begin
                        free_q     <= 1'b1;
                        free_idx_q <= idx_q;
                     end
                     if (idx_q == NUM_DATA_LOG2'(N - 1)) begin
                        state_q <= S_COMMIT;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end
               end
               S_COMMIT: begin
                  hit_q   <= match_q;
                  state_q <= S_IDLE;
                  unique case (op_q)
                     OP_WRITE: begin
                        if (match_q) begin
                           data_q[match_idx_q] <= data_l_q;
                        end else if (free_q) begin
                           valid_q[free_idx_q] <= 1'b1;
                           key_q[free_idx_q]   <= key_l_q;
                           data_q[free_idx_q]  <= data_l_q;
                           count_q             <= count_q + 1'b1;
                        end else if (REPLACE_EN) begin
                           // Full table: victim is the round-robin slot; rr_q wraps mod N.
                           key_q[rr_q]  <= key_l_q;
                           data_q[rr_q] <= data_l_q;
                           rr_q         <= rr_q + 1'b1;
                        end else begin
                           error_q <= 1'b1;
                        end
                     end
                     OP_DELETE: begin
                        if (match_q) begin
                           valid_q[match_idx_q] <= 1'b0;
                           count_q              <= count_q - 1'b1;
                        end else begin
                           error_q <= 1'b1;
                        end
                     end
                     OP_LOOKUP: begin
                        if (match_q) begin
                           data_out_q   <= data_q[match_idx_q];
                           data_valid_q <= 1'b1;
                        end else begin
                           data_valid_q <= 1'b0;
                           error_q      <= 1'b1;
                        end
                     end
                     default: state_q <= S_IDLE;
                  endcase
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign data_output = data_out_q;
   assign data_valid  = data_valid_q;
   assign hit         = hit_q;
   assign error       = error_q;
   assign busy        = (state_q != S_IDLE);
   assign count       = count_q;
   assign full        = (count_q == (NUM_DATA_LOG2 + 1)'(N));

endmodule

// File: tb/tb_assoc_lookup_unit.sv
// ---------------------------------------------------------------------------
// tb_assoc_lookup_unit
//   Directed bench for assoc_lookup_unit. Two instances share all inputs:
//   u_rep (REPLACE_EN=1) and u_norep (REPLACE_EN=0); they behave identically
//   except for writes of a new key into a full table.
// ---------------------------------------------------------------------------
module tb_assoc_lookup_unit;

   logic       clk;
   logic       sync_reset;
   logic [3:0] cmd;
   logic [3:0] key;
   logic [1:0] din;

   logic [1:0] dout_r, dout_n;
   logic       dv_r, dv_n, hit_r, hit_n, err_r, err_n, busy_r, busy_n, full_r, full_n;
   logic [3:0] cnt_r, cnt_n;

   int checks;
   int errors;
   int errcnt_r;
   int errcnt_n;
   int n;

   assoc_lookup_unit #(
      .KEY_WIDTH(4), .DATA_WIDTH(2), .NUM_DATA_LOG2(3), .REPLACE_EN(1'b1)
   ) u_rep (
      .clk(clk), .sync_reset(sync_reset), .cmd_input(cmd), .key_input(key),
      .data_input(din), .data_output(dout_r), .data_valid(dv_r), .hit(hit_r),
      .error(err_r), .busy(busy_r), .count(cnt_r), .full(full_r)
   );

   assoc_lookup_unit #(
      .KEY_WIDTH(4), .DATA_WIDTH(2), .NUM_DATA_LOG2(3), .REPLACE_EN(1'b0)
   ) u_norep (
      .clk(clk), .sync_reset(sync_reset), .cmd_input(cmd), .key_input(key),
      .data_input(din), .data_output(dout_n), .data_valid(dv_n), .hit(hit_n),
      .error(err_n), .busy(busy_n), .count(cnt_n), .full(full_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-edge command: line high for a single sampled edge, then low.
   task automatic issue(input logic [3:0] c, input logic [3:0] k, input logic [1:0] d);
      errcnt_r = 0;
      errcnt_n = 0;
      cmd = c;
      key = k;
      din = d;
      tick;
      cmd = 4'b0000;
   endtask

   // Counts remaining busy cycles and error pulses of both instances.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while ((busy_r || busy_n) && cyc < 40) begin
         tick;
         cyc++;
         errcnt_r += int'(err_r);
         errcnt_n += int'(err_n);
      end
      check("wait_bound", 32'(busy_r | busy_n), 32'd0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      errcnt_r   = 0;
      errcnt_n   = 0;
      sync_reset = 1'b1;
      cmd        = 4'b0010;   // lookup line held through reset
      key        = 4'h5;
      din        = 2'b00;
      tick;
      tick;

      // Reset state
      check("rst_busy",  32'(busy_r), 32'd0);
      check("rst_count", 32'(cnt_r),  32'd0);
      check("rst_full",  32'(full_r), 32'd0);
      check("rst_dv",    32'(dv_r),   32'd0);
      check("rst_hit",   32'(hit_r),  32'd0);
      check("rst_err",   32'(err_r),  32'd0);
      check("rst_dout",  32'(dout_r), 32'd0);
      check("rst_busy_n", 32'(busy_n), 32'd0);

      // Held lookup line fires once after release: empty-table miss of key 5
      sync_reset = 1'b0;
      tick;
      check("held_rst_accept", 32'(busy_r), 32'd1);
      wait_done(n);
      check("miss_busy_cycles", 32'(n), 32'd10 - 32'd1);
      check("miss_err_pulses", 32'(errcnt_r), 32'd1);
      check("miss_hit", 32'(hit_r), 32'd0);
      check("miss_dv",  32'(dv_r),  32'd0);
      tick;
      check("miss_err_once", 32'(err_r), 32'd0);
      check("held_no_retrigger", 32'(busy_r), 32'd0);
      cmd = 4'b0000;
      tick;

      // Write (3, 2'b10) then lookup 3
      issue(4'b0001, 4'h3, 2'b10);
      wait_done(n);
      check("wr3_cycles", 32'(n), 32'd9);
      check("wr3_count",  32'(cnt_r), 32'd1);
      check("wr3_hit",    32'(hit_r), 32'd0);
      check("wr3_err",    32'(errcnt_r), 32'd0);
      issue(4'b0010, 4'h3, 2'b00);
      wait_done(n);
      check("lk3_cycles", 32'(n), 32'd2);
      check("lk3_dout",   32'(dout_r), 32'd2);
      check("lk3_dv",     32'(dv_r), 32'd1);
      check("lk3_hit",    32'(hit_r), 32'd1);

      // Delete 3, then lookup 3 misses with data_output held
      issue(4'b0100, 4'h3, 2'b00);
      wait_done(n);
      check("del3_count", 32'(cnt_r), 32'd0);
      check("del3_hit",   32'(hit_r), 32'd1);
      issue(4'b0010, 4'h3, 2'b00);
      wait_done(n);
      check("lk3b_dv",   32'(dv_r), 32'd0);
      check("lk3b_dout", 32'(dout_r), 32'd2);
      check("lk3b_err",  32'(errcnt_r), 32'd1);
      check("lk3b_hit",  32'(hit_r), 32'd0);

      // Write line held high: exactly one write executes
      cmd = 4'b0001;
      key = 4'h7;
      din = 2'b01;
      repeat (11) tick;
      check("hold_busy",  32'(busy_r), 32'd0);
      check("hold_count", 32'(cnt_r), 32'd1);
      cmd = 4'b0000;
      tick;

      // Clear from idle
      issue(4'b1000, 4'h0, 2'b00);
      check("clr_count", 32'(cnt_r), 32'd0);
      check("clr_busy",  32'(busy_r), 32'd0);

      // Write+lookup same edge, delete edge during SCAN
      issue(4'b0011, 4'hA, 2'b11);
      cmd = 4'b0100;
      tick;
      cmd = 4'b0000;
      wait_done(n);
      check("wl_cycles", 32'(n), 32'd8);
      check("wl_count",  32'(cnt_r), 32'd1);
      check("wl_dv",     32'(dv_r), 32'd0);
      issue(4'b0010, 4'hA, 2'b00);
      wait_done(n);
      check("lkA_dout", 32'(dout_r), 32'd3);
      check("lkA_dv",   32'(dv_r), 32'd1);

      // Clear mid-SCAN of a lookup
      issue(4'b0010, 4'hF, 2'b00);
      tick;
      tick;
      check("pre_clr_busy", 32'(busy_r), 32'd1);
      issue(4'b1000, 4'h0, 2'b00);
      check("mclr_count", 32'(cnt_r), 32'd0);
      check("mclr_dv",    32'(dv_r), 32'd0);
      check("mclr_busy",  32'(busy_r), 32'd0);
      check("mclr_hit",   32'(hit_r), 32'd0);
      errcnt_r = 0;
      repeat (10) begin
         tick;
         errcnt_r += int'(err_r);
      end
      check("mclr_no_err",  32'(errcnt_r), 32'd0);
      check("mclr_dout",    32'(dout_r), 32'd3);

      // Fill keys 0..7 (data = key[1:0]), then write key 9
      for (int k = 0; k < 8; k++) begin
         issue(4'b0001, 4'(k), 2'(k));
         wait_done(n);
      end
      check("fill_count_r", 32'(cnt_r), 32'd8);
      check("fill_full_r",  32'(full_r), 32'd1);
      check("fill_count_n", 32'(cnt_n), 32'd8);
      check("fill_full_n",  32'(full_n), 32'd1);
      issue(4'b0001, 4'h9, 2'b01);
      wait_done(n);
      check("w9_err_r",   32'(errcnt_r), 32'd0);
      check("w9_err_n",   32'(errcnt_n), 32'd1);
      check("w9_count_r", 32'(cnt_r), 32'd8);
      check("w9_count_n", 32'(cnt_n), 32'd8);
      check("w9_full_r",  32'(full_r), 32'd1);

      issue(4'b0010, 4'h0, 2'b00);
      wait_done(n);
      check("lk0_dv_r",   32'(dv_r), 32'd0);
      check("lk0_err_r",  32'(errcnt_r), 32'd1);
      check("lk0_dout_r", 32'(dout_r), 32'd3);
      check("lk0_dv_n",   32'(dv_n), 32'd1);
      check("lk0_dout_n", 32'(dout_n), 32'd0);
      check("lk0_hit_n",  32'(hit_n), 32'd1);

      issue(4'b0010, 4'h9, 2'b00);
      wait_done(n);
      check("lk9_dv_r",   32'(dv_r), 32'd1);
      check("lk9_dout_r", 32'(dout_r), 32'd1);
      check("lk9_hit_r",  32'(hit_r), 32'd1);
      check("lk9_dv_n",   32'(dv_n), 32'd0);
      check("lk9_err_n",  32'(errcnt_n), 32'd1);
      check("lk9_dout_n", 32'(dout_n), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/assoc_lookup_unit.md
ASSOC_LOOKUP_UNIT -- requirements
Module: assoc_lookup_unit

Interface
REQ-001 Parameter KEY_WIDTH, default 4, key bits per entry.
REQ-002 Parameter DATA_WIDTH, default 2, data bits per entry.
REQ-003 Parameter NUM_DATA_LOG2, default 3, log2 of entry count N (N = 8 by default).
REQ-004 Parameter REPLACE_EN, default 1, 1 = write of a new key into a full table overwrites the round-robin victim, 0 = such a write is rejected with error.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 sync_reset  input  1  reset, synchronous and active-high.
REQ-007 cmd_input  input  4  raw level command lines: bit0 write, bit1 lookup, bit2 delete, bit3 clear.
REQ-008 key_input  input  KEY_WIDTH  command key.
REQ-009 data_input  input  DATA_WIDTH  write data.
REQ-010 data_output  output  DATA_WIDTH  data of the last successful lookup.
REQ-011 data_valid  output  1  data_output holds a valid lookup result.
REQ-012 hit  output  1  last completed command found its key.
REQ-013 error  output  1  one-cycle pulse on a failed command.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.
REQ-015 count  output  NUM_DATA_LOG2+1  number of valid entries, 0..N.
REQ-016 full  output  1  count == N.

Function
REQ-017 Each cmd_input bit passes through a rising-edge detector: a previous-sample register and a one-cycle pulse when the current sample is 1 and the previous sample is 0.
REQ-018 Simultaneous pulses resolve by priority: clear > write > delete > lookup; lower-priority pulses in the same cycle are discarded.
REQ-019 Pulses other than clear arriving while busy = 1 are discarded without effect or error.
REQ-020 The FSM has three states: IDLE, SCAN and COMMIT.
REQ-021 In IDLE, a write, delete or lookup pulse latches the opcode, key_input and data_input into registers and moves the FSM to SCAN with the scan index at 0.
REQ-022 SCAN examines one entry per cycle at indices 0..N-1 and records the lowest invalid index seen as the free slot.
REQ-023 SCAN moves to COMMIT in the cycle after the first entry that is valid and has a matching key (hit), or after index N-1 is examined with no match (miss).
REQ-024 A command whose match is at index k therefore occupies k+1 SCAN cycles and 1 COMMIT cycle; a miss occupies N+1 cycles; outputs update on the COMMIT edge and the FSM then returns to IDLE.
REQ-025 Write hit: overwrite the matching entry's data; count is unchanged.
REQ-026 Write miss, not full: store key and data at the lowest free index and increment count.
REQ-027 Write miss, full, REPLACE_EN=1: overwrite the entry at the round-robin pointer, then advance the pointer modulo N; count is unchanged.
REQ-028 Write miss, full, REPLACE_EN=0: no change to the table; error pulses.
REQ-029 Delete hit: invalidate the matching entry and decrement count.
REQ-030 Delete miss: no change to the table; error pulses.
REQ-031 Lookup hit: data_output takes the entry's data and data_valid is set to 1.
REQ-032 Lookup miss: data_valid is cleared to 0, data_output is held, and error pulses.
REQ-033 data_output and data_valid change only on lookup COMMIT or clear.
REQ-034 hit is updated on every COMMIT.
REQ-035 Clear is accepted in any state and completes in one cycle: all entries invalid, count 0, round-robin pointer 0, data_valid 0, hit 0, FSM to IDLE.
REQ-036 A clear aborts any command in progress; the aborted command has no effect on the table or outputs.
REQ-037 A delete does not move the round-robin pointer.
REQ-038 Keys are unique: after any sequence of commands, no two valid entries hold the same key.

Reset
REQ-039 While sync_reset = 1 at a clock edge: all entries invalid, count 0, full 0, round-robin pointer 0, FSM IDLE, busy 0, data_output 0, data_valid 0, hit 0, error 0, and edge-detector registers loaded with 0.
REQ-040 sync_reset takes priority over every command, including a command in progress, which is abandoned; a cmd_input line held high through reset produces one pulse on the first edge after release.

Verification
REQ-041 Empty table, lookup key 4'h5 -> busy for 9 cycles, then data_valid=0, hit=0, error pulses once.
REQ-042 Write (4'h3, 2'b10), then lookup 4'h3 -> count=1; lookup completes in 2 cycles with data_output=2'b10, data_valid=1, hit=1.
REQ-043 Write 8 distinct keys 0..7, then write key 9 with data 2'b01, REPLACE_EN=1 -> key 0 replaced, count=8, full=1; lookup 0 misses; lookup 9 returns 2'b01.
REQ-044 Same as REQ-043 with REPLACE_EN=0 -> error pulses, table unchanged, lookup 9 misses.
REQ-045 Write and lookup edges on the same cycle, then a delete edge during SCAN -> only the write executes and the delete is ignored; then a clear issued mid-SCAN of a lookup -> count=0, data_valid=0, busy=0 on the next cycle.
REQ-046 Delete of a present key -> count decrements by 1 and a later lookup of that key misses; a cmd_input line held high for 10 cycles -> exactly one command executes.
